// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage of the accumulator processor.
// Samples the committed PC on a Fetch request and aligns it to a word
// address. It then runs a req/ack read on instruction memory and latches the
// returned word into the instruction register.
// Optional feature: define FETCH_TIMEOUT_EN to add a REQ watchdog. On expiry
// the unit drops MemReq, enters ERR and raises the sticky FetchErr flag.
module instruction_fetch_unit #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Fetch,
  input  logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemReq,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] IRout,
  output logic [2:0]        Opcode,
  output logic [12:0]       IRimm,
  output logic              FetchDone,
  output logic              Busy,
  output logic              FetchErr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Clearing bit 0 with a mask keeps every PC bit on the datapath.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(1));

  // A watchdog limit outside 1..255 cannot be represented by the 8-bit counter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("instruction_fetch_unit: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              accept_s;
  logic              ack_s;

`ifdef FETCH_TIMEOUT_EN
  // The watchdog fires on the REQ cycle whose counter holds the final count.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       expire_s;
`endif

  // Register stage: FSM state, latched address, instruction register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ir_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Acceptance of a new fetch and a valid acknowledge. Ack counts only in REQ.
  always_comb begin
    accept_s = Fetch && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    ack_s    = (state_q == S_REQ) && MemAck;
`ifdef FETCH_TIMEOUT_EN
    expire_s = (state_q == S_REQ) && !MemAck && (cnt_q == TIMEOUT_LAST);
`endif
  end

  // Next-state logic: one fetch in flight, back-to-back acceptance from DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (Fetch) state_d = S_REQ;
        else       state_d = S_IDLE;
      end
      S_REQ: begin
        if (MemAck) state_d = S_DONE;
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) state_d = S_ERR;
`endif
        else state_d = S_REQ;
      end
      S_DONE: begin
        if (Fetch) state_d = S_REQ;
        else       state_d = S_IDLE;
      end
`ifdef FETCH_TIMEOUT_EN
      S_ERR: begin
        if (Fetch) state_d = S_REQ;
        else       state_d = S_ERR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath updates: the address latches on acceptance, IR loads on a REQ ack.
  always_comb begin
    if (accept_s) addr_d = PC & ALIGN_MASK;
    else          addr_d = addr_q;
    if (ack_s) ir_d = MemData;
    else       ir_d = ir_q;
`ifdef FETCH_TIMEOUT_EN
    if (accept_s)                         cnt_d = 8'd0;
    else if (state_q == S_REQ && !MemAck) cnt_d = cnt_q + 8'd1;
    else                                  cnt_d = cnt_q;
    if (accept_s)      err_d = 1'b0;
    else if (expire_s) err_d = 1'b1;
    else               err_d = err_q;
`endif
  end

  // Output decode: every output comes from state or a flop, never from MemAck.
  always_comb begin
    MemReq    = (state_q == S_REQ);
    Busy      = (state_q == S_REQ);
    FetchDone = (state_q == S_DONE);
    MemAddr   = addr_q;
    IRout     = ir_q;
    Opcode    = ir_q[15:13];
    IRimm     = ir_q[12:0];
`ifdef FETCH_TIMEOUT_EN
    FetchErr  = err_q;
`else
    FetchErr  = 1'b0;
`endif
  end

endmodule
